// File: rtl/axilite_cmd_master.sv
// Single-outstanding AXI4-Lite master: one valid/ready command becomes one AXI-lite read or write.
// Latency: AW/W or AR valid the cycle after cmd accept; rsp valid the cycle after the B/R beat.
// Backpressure: AXI valids hold until handshake, rsp holds until rsp_ready_i; AXILITE_CMD_MASTER_TIMEOUT_EN bounds B/R waits.
module axilite_cmd_master #(
    parameter int axi_addr_width_p = 32,
    parameter int axi_data_width_p = 32,
    parameter int timeout_p        = 256
) (
    input  logic                        clk_i,
    input  logic                        reset_i,

    input  logic                        cmd_valid_i,
    output logic                        cmd_ready_o,
    input  logic                        cmd_we_i,
    input  logic [axi_addr_width_p-1:0] cmd_addr_i,
    input  logic [axi_data_width_p-1:0] cmd_wdata_i,

    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic [axi_data_width_p-1:0] rsp_rdata_o,
    output logic [1:0]                  rsp_resp_o,
    output logic                        rsp_we_o,

    output logic [axi_addr_width_p-1:0] axi_awaddr_o,
    output logic                        axi_awvalid_o,
    input  logic                        axi_awready_i,

    output logic [axi_data_width_p-1:0] axi_wdata_o,
    output logic                        axi_wlast_o,
    output logic                        axi_wvalid_o,
    input  logic                        axi_wready_i,

    input  logic [1:0]                  axi_bresp_i,
    input  logic                        axi_bvalid_i,
    output logic                        axi_bready_o,

    output logic [axi_addr_width_p-1:0] axi_araddr_o,
    output logic                        axi_arvalid_o,
    input  logic                        axi_arready_i,

    input  logic [axi_data_width_p-1:0] axi_rdata_i,
    input  logic [1:0]                  axi_rresp_i,
    input  logic                        axi_rlast_i,
    input  logic                        axi_rvalid_i,
    output logic                        axi_rready_o
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RSP
    } state_t;

    typedef struct packed {
        logic                        we;
        logic [axi_addr_width_p-1:0] addr;
        logic [axi_data_width_p-1:0] wdata;
    } cmd_t;

    state_t                        state;
    state_t                        state_nxt;
    cmd_t                          cmd_q;
    logic                          aw_pend;
    logic                          w_pend;
    logic [axi_data_width_p-1:0]   rdata_q;
    logic [1:0]                    resp_q;
    logic                          tmo_hit;

    // Single-beat transfers only: the R beat is always the last one.
    logic unused_rlast;
    assign unused_rlast = axi_rlast_i;

`ifdef AXILITE_CMD_MASTER_TIMEOUT_EN
    localparam int tmo_w = $clog2(timeout_p + 1);
    logic [tmo_w-1:0] tmo_cnt;

    // Held at zero outside the response-wait states, so it reads 0 on the first waiting cycle.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            tmo_cnt <= '0;
        end else if (state == WR_RESP || state == RD_DATA) begin
            tmo_cnt <= tmo_cnt + tmo_w'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign tmo_hit = (tmo_cnt == tmo_w'(timeout_p - 1));
`else
    localparam int unused_timeout_p = timeout_p;
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_valid_i) begin
                    state_nxt = cmd_we_i ? WR : RD_ADDR;
                end
            end
            WR: begin
                // AW and W retire independently; leave once neither is still pending.
                if ((!aw_pend || axi_awready_i) && (!w_pend || axi_wready_i)) begin
                    state_nxt = WR_RESP;
                end
            end
            WR_RESP: begin
                if (axi_bvalid_i || tmo_hit) begin
                    state_nxt = RSP;
                end
            end
            RD_ADDR: begin
                if (axi_arready_i) begin
                    state_nxt = RD_DATA;
                end
            end
            RD_DATA: begin
                if (axi_rvalid_i || tmo_hit) begin
                    state_nxt = RSP;
                end
            end
            RSP: begin
                if (rsp_ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cmd_q   <= '0;
            aw_pend <= 1'b0;
            w_pend  <= 1'b0;
            rdata_q <= '0;
            resp_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        cmd_q   <= '{we: cmd_we_i, addr: cmd_addr_i, wdata: cmd_wdata_i};
                        aw_pend <= cmd_we_i;
                        w_pend  <= cmd_we_i;
                    end
                end
                WR: begin
                    if (axi_awready_i) aw_pend <= 1'b0;
                    if (axi_wready_i)  w_pend  <= 1'b0;
                end
                WR_RESP: begin
                    if (axi_bvalid_i) begin
                        resp_q  <= axi_bresp_i;
                        rdata_q <= '0;
                    end else if (tmo_hit) begin
                        resp_q  <= 2'b10;
                        rdata_q <= '0;
                    end
                end
                RD_DATA: begin
                    if (axi_rvalid_i) begin
                        resp_q  <= axi_rresp_i;
                        rdata_q <= axi_rdata_i;
                    end else if (tmo_hit) begin
                        resp_q  <= 2'b10;
                        rdata_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Everything below is a register or a state decode; no AXI input reaches an AXI output.
    assign cmd_ready_o   = (state == IDLE);
    assign rsp_valid_o   = (state == RSP);
    assign rsp_rdata_o   = rdata_q;
    assign rsp_resp_o    = resp_q;
    assign rsp_we_o      = cmd_q.we;

    assign axi_awaddr_o  = cmd_q.addr;
    assign axi_awvalid_o = aw_pend;
    assign axi_wdata_o   = cmd_q.wdata;
    assign axi_wlast_o   = 1'b1;
    assign axi_wvalid_o  = w_pend;
    assign axi_bready_o  = (state == WR_RESP);

    assign axi_araddr_o  = cmd_q.addr;
    assign axi_arvalid_o = (state == RD_ADDR);
    assign axi_rready_o  = (state == RD_DATA);

endmodule

// File: doc/axilite_cmd_master.md
Name: axilite_cmd_master

Overview:
- Single-outstanding AXI4-Lite master that sits directly upstream of the AXI-lite memory slave and drives its AW/W/B/AR/R channels.
- Converts a simple valid/ready command stream (read or write, address, data) into one AXI-lite transaction at a time.
- Returns a valid/ready response carrying read data and the AXI response code.
- Used by benches and small controllers to reach the memory without hand-sequencing channels.

Parameters:
- axi_addr_width_p, 32, AXI address width and cmd address width.
- axi_data_width_p, 32, AXI data width and cmd/rsp data width.
- timeout_p, 256, cycles to wait for B/R before forcing an error; used only with the optional feature.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_addr_i  in  axi_addr_width_p  byte address.
- cmd_wdata_i  in  axi_data_width_p  write data.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed.
- rsp_rdata_o  out  axi_data_width_p  read data; 0 for writes.
- rsp_resp_o  out  2  captured BRESP/RRESP.
- rsp_we_o  out  1  echo of the command type.
- axi_awaddr_o  out  axi_addr_width_p; axi_awvalid_o  out  1; axi_awready_i  in  1.
- axi_wdata_o  out  axi_data_width_p; axi_wlast_o  out  1; axi_wvalid_o  out  1; axi_wready_i  in  1.
- axi_bresp_i  in  2; axi_bvalid_i  in  1; axi_bready_o  out  1.
- axi_araddr_o  out  axi_addr_width_p; axi_arvalid_o  out  1; axi_arready_i  in  1.
- axi_rdata_i  in  axi_data_width_p; axi_rresp_i  in  2; axi_rlast_i  in  1; axi_rvalid_i  in  1; axi_rready_o  out  1.

Behaviour:
- All outputs are registered or decoded from state; no combinational path from AXI inputs to AXI outputs.
- Reset (reset_i low, asynchronous):
  - state = IDLE; all valid outputs = 0; axi_bready_o = axi_rready_o = 0.
  - Address, data and rsp registers = 0.
  - Reset mid-transaction abandons it; no recovery is attempted.
- FSM states: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE:
  - cmd_ready_o = 1 in IDLE only.
  - On cmd handshake, latch addr, wdata and we.
  - Write: next state WR with awvalid = wvalid = 1. Read: next state RD_ADDR with arvalid = 1.
- WR:
  - awvalid and wvalid drop independently on their own handshake; either may complete first or both in the same cycle.
  - When both are done, go to WR_RESP with bready = 1.
  - axi_wlast_o is constant 1.
  - AW/W address and data stay stable while valid.
- WR_RESP: on bvalid, capture bresp, set rsp_rdata = 0, go to RSP; bready drops.
- RD_ADDR: on arready, go to RD_DATA with rready = 1.
- RD_DATA:
  - On rvalid, capture rdata and rresp, go to RSP.
  - axi_rlast_i is ignored functionally.
- RSP: rsp_valid_o = 1; rsp fields hold until rsp_ready_i; then IDLE.
- Latency:
  - Zero-wait slave: rsp_valid_o rises 3 cycles after the cmd handshake edge for writes, and 3 for reads.
  - Next cmd_ready_o comes 1 cycle after the rsp handshake.
- A B or R beat arriving with no transaction outstanding is not accepted, since bready and rready are 0 outside their states.
- AXI valids never drop before their handshake; the slave may stall indefinitely.

Optional Feature:
- Macro: AXILITE_CMD_MASTER_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WR_RESP or RD_DATA and increments each cycle in those states.
  - If it reaches timeout_p-1 without bvalid/rvalid, go to RSP with rsp_resp_o = 2'b10 (SLVERR) and rsp_rdata_o = 0.
  - bready/rready drop.
- Not defined: no counter; the block waits forever.

Test Plan:
- Write addr 0x10, data 0xDEADBEEF, zero-wait slave -> AW and W handshake the same cycle; rsp_valid_o 3 cycles after cmd; rsp_resp_o = 0, rsp_we_o = 1, rsp_rdata_o = 0.
- Read addr 0x10 after that write -> araddr = 0x10; rsp_rdata_o = 0xDEADBEEF, rsp_resp_o = 0.
- Slave holds awready low 4 cycles, wready 1 cycle -> wvalid drops after 1 cycle, awvalid held 4 with awaddr stable; bready asserted only after both handshakes.
- rsp_ready_i held low 5 cycles -> rsp fields stable; cmd_ready_o stays 0; second cmd is accepted the cycle after release.
- Reset pulled low while in RD_DATA -> arvalid/rready/rsp_valid_o = 0 immediately; after release, cmd_ready_o = 1 and a new read of 0x10 returns 0xDEADBEEF.
- With AXILITE_CMD_MASTER_TIMEOUT_EN, timeout_p = 8, bvalid never asserted -> rsp_valid_o after 8 cycles in WR_RESP with rsp_resp_o = 2'b10.
